// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares data-memory port 2 between the CPU load/store path and the external
// debug/program loader. Each grant runs a fixed IDLE -> ACCESS -> WAIT -> RESP
// sequence, so every access takes exactly four cycles from grant to idle.
// EXT may keep ownership across a locked burst, but only for MAX_BURST grants
// while the CPU is waiting.
module mem_port_arbiter #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_size,
    input  logic        cpu_sign,
    output logic        cpu_stall,
    output logic        cpu_done,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic        ext_lock,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    output logic        ext_done,
    output logic [31:0] ext_rdata,
    output logic        mem_rden2,
    output logic        mem_we2,
    output logic [31:0] mem_addr2,
    output logic [31:0] mem_din2,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_dout2
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic       OWN_CPU     = 1'b0;
    localparam logic       OWN_EXT     = 1'b1;
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    // Burst counter stops at 255 instead of wrapping back into lock range.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic [7:0]  burst_cnt_q, burst_cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        lock_win;
    logic        winner;

    // State and datapath registers; last_owner resets to EXT so the CPU wins the first tie.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_EXT;
            burst_cnt_q  <= 8'd0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            rdata_q      <= rdata_d;
        end
    end

    // Winner selection: locked EXT burst first, then sole requester, then alternate.
    always_comb begin
        lock_win = last_owner_q & (burst_cnt_q != 8'd0) & ext_req &
                   (burst_cnt_q < MAX_BURST_C);
        winner   = OWN_CPU;
        if (lock_win) begin
            winner = OWN_EXT;
        end else if (cpu_req & ~ext_req) begin
            winner = OWN_CPU;
        end else if (ext_req & ~cpu_req) begin
            winner = OWN_EXT;
        end else begin
            winner = ~last_owner_q;
        end
    end

    // Sequencer next-state; requests are only looked at in IDLE.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req | ext_req) begin
                    owner_d = winner;
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                rdata_d = mem_dout2;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                last_owner_d = owner_q;
                if ((owner_q == OWN_EXT) && ext_lock) begin
                    burst_cnt_d = sat_inc8(burst_cnt_q);
                end else begin
                    burst_cnt_d = 8'd0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory pins carry the owner's fields only during ACCESS; done/rdata only in RESP.
    always_comb begin
        mem_rden2 = 1'b0;
        mem_we2   = 1'b0;
        mem_addr2 = 32'd0;
        mem_din2  = 32'd0;
        mem_size  = 2'b00;
        mem_sign  = 1'b0;
        cpu_done  = 1'b0;
        cpu_rdata = 32'd0;
        ext_done  = 1'b0;
        ext_rdata = 32'd0;
        if (state_q == ST_ACCESS) begin
            if (owner_q == OWN_EXT) begin
                mem_rden2 = ~ext_we;
                mem_we2   = ext_we;
                mem_addr2 = ext_addr;
                mem_din2  = ext_wdata;
                mem_size  = 2'b10;
                mem_sign  = 1'b0;
            end else begin
                mem_rden2 = ~cpu_we;
                mem_we2   = cpu_we;
                mem_addr2 = cpu_addr;
                mem_din2  = cpu_wdata;
                mem_size  = cpu_size;
                mem_sign  = cpu_sign;
            end
        end else begin
            mem_rden2 = 1'b0;
            mem_we2   = 1'b0;
        end
        if (state_q == ST_RESP) begin
            if (owner_q == OWN_EXT) begin
                ext_done  = 1'b1;
                ext_rdata = rdata_q;
            end else begin
                cpu_done  = 1'b1;
                cpu_rdata = rdata_q;
            end
        end else begin
            cpu_done = 1'b0;
            ext_done = 1'b0;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model (grant -> +1 memory
// access -> +3 done) with a model memory, a port-2 memory device, directed
// scenarios with hand-computed expectations, and a randomized two-requester run.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sign = 1'b0;
    logic [31:0] cpu_addr = 32'd0, cpu_wdata = 32'd0;
    logic [1:0]  cpu_size = 2'b00;
    logic        cpu_stall, cpu_done;
    logic [31:0] cpu_rdata;
    logic        ext_req = 1'b0, ext_we = 1'b0, ext_lock = 1'b0;
    logic [31:0] ext_addr = 32'd0, ext_wdata = 32'd0;
    logic        ext_done;
    logic [31:0] ext_rdata;
    logic        mem_rden2, mem_we2, mem_sign;
    logic [31:0] mem_addr2, mem_din2;
    logic [1:0]  mem_size;
    logic [31:0] mem_dout2 = 32'd0;

    mem_port_arbiter #(.MAX_BURST(MAXB)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_stall(cpu_stall),
        .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_done(ext_done), .ext_rdata(ext_rdata),
        .mem_rden2(mem_rden2), .mem_we2(mem_we2), .mem_addr2(mem_addr2),
        .mem_din2(mem_din2), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_dout2(mem_dout2)
    );

    initial forever #5 CLK = ~CLK;

    int passed = 0, total = 0, cyc = 0, start = 0;
    logic [31:0] dev_mem [logic [31:0]];
    logic [31:0] mm [logic [31:0]];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC3A5_0F1E;
    endfunction

    // Port-2 memory device: synchronous read, garbage when not reading.
    initial forever begin
        @(posedge CLK);
        if (mem_rden2) mem_dout2 <= dev_mem.exists(mem_addr2) ? dev_mem[mem_addr2] : dflt(mem_addr2);
        else           mem_dout2 <= $urandom;
        if (mem_we2) dev_mem[mem_addr2] = mem_din2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        dev_mem[a] = d;
        mm[a] = d;
    endtask

    // ---------------- reference model ----------------
    int          mk = 0;              // cycles since grant, 0 = free
    bit          m_owner = 1'b0, m_last = 1'b1;
    int          m_burst = 0;
    bit          f_we, f_sign;
    logic [31:0] f_addr, f_wdata, exp_rd;
    logic [1:0]  f_size;
    int          n_grant [2];

    task automatic model_step();
        bit w;
        if (RST) begin
            mk = 0; m_owner = 1'b0; m_last = 1'b1; m_burst = 0;
            return;
        end
        case (mk)
            0: if (cpu_req || ext_req) begin
                if (m_last && m_burst > 0 && ext_req && m_burst < MAXB) w = 1'b1;
                else if (cpu_req && !ext_req) w = 1'b0;
                else if (ext_req && !cpu_req) w = 1'b1;
                else w = !m_last;
                m_owner = w;
                n_grant[w]++;
                if (w) begin
                    f_we = ext_we; f_addr = ext_addr; f_wdata = ext_wdata; f_size = 2'b10; f_sign = 1'b0;
                end else begin
                    f_we = cpu_we; f_addr = cpu_addr; f_wdata = cpu_wdata; f_size = cpu_size; f_sign = cpu_sign;
                end
                mk = 1;
            end
            1: begin
                if (f_we) mm[f_addr] = f_wdata;
                else exp_rd = mm.exists(f_addr) ? mm[f_addr] : dflt(f_addr);
                mk = 2;
            end
            2: mk = 3;
            3: begin
                m_last = m_owner;
                m_burst = (m_owner && ext_lock) ? ((m_burst < 255) ? m_burst + 1 : 255) : 0;
                mk = 0;
            end
            default: mk = 0;
        endcase
    endtask

    task automatic compare();
        bit acc, cd, ed;
        acc = (mk == 1);
        cd  = (mk == 3) && !m_owner;
        ed  = (mk == 3) && m_owner;
        chk("mem_rden2", mem_rden2, acc && !f_we);
        chk("mem_we2",   mem_we2,   acc && f_we);
        chk("mem_addr2", mem_addr2, acc ? f_addr : 32'd0);
        chk("mem_din2",  mem_din2,  acc ? f_wdata : 32'd0);
        chk("mem_size",  mem_size,  acc ? f_size : 2'b00);
        chk("mem_sign",  mem_sign,  acc && f_sign);
        chk("cpu_done",  cpu_done,  cd);
        chk("ext_done",  ext_done,  ed);
        chk("cpu_stall", cpu_stall, cpu_req && !cd);
        if (!(cd && f_we)) chk("cpu_rdata", cpu_rdata, cd ? exp_rd : 32'd0);
        if (!(ed && f_we)) chk("ext_rdata", ext_rdata, ed ? exp_rd : 32'd0);
    endtask

    // ---------------- observation of DUT events ----------------
    int first_cd, first_ed, cd_cnt, ed_cnt, nseq, wcnt;
    logic [31:0] seq;

    task automatic monitor();
        if (cpu_done) begin
            cd_cnt++; seq = {seq[30:0], 1'b0}; nseq++;
            if (first_cd < 0) first_cd = cyc - start;
        end
        if (ext_done) begin
            ed_cnt++; seq = {seq[30:0], 1'b1}; nseq++;
            if (first_ed < 0) first_ed = cyc - start;
        end
        if (mem_we2 && mem_addr2 == 32'h2003 && mem_din2 == 32'h0000_00A5 && mem_size == 2'b00) wcnt++;
    endtask

    task automatic mark();
        start = cyc; first_cd = -1; first_ed = -1; cd_cnt = 0; ed_cnt = 0;
        nseq = 0; seq = 32'd0; wcnt = 0; n_grant[0] = 0; n_grant[1] = 0;
    endtask

    // ---------------- requester agents ----------------
    int cpu_left = 0, ext_left = 0;
    bit rnd = 1'b0;

    task automatic cpu_new();
        if (rnd) begin
            cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
            cpu_wdata = $urandom; cpu_size = 2'($urandom_range(0, 2)); cpu_sign = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic ext_new();
        if (rnd) begin
            ext_we = 1'($urandom_range(0, 1)); ext_addr = 32'h100 + 32'($urandom_range(0, 3)) * 32'd4;
            ext_wdata = $urandom; ext_lock = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic agents();
        if (cpu_req && mk == 3 && !m_owner) begin
            cpu_left--;
            if (cpu_left > 0 && (!rnd || $urandom_range(0, 1) == 1)) cpu_new(); else cpu_req = 1'b0;
        end else if (!cpu_req && cpu_left > 0 && (!rnd || $urandom_range(0, 3) == 0)) begin
            cpu_new(); cpu_req = 1'b1;
        end
        if (ext_req && mk == 3 && m_owner) begin
            ext_left--;
            if (ext_left > 0 && (!rnd || $urandom_range(0, 1) == 1)) ext_new(); else ext_req = 1'b0;
        end else if (!ext_req && ext_left > 0 && (!rnd || $urandom_range(0, 3) == 0)) begin
            ext_new(); ext_req = 1'b1;
        end
    endtask

    task automatic tick();
        agents();
        @(posedge CLK);
        model_step();
        cyc++;
        @(negedge CLK);
        compare();
        monitor();
    endtask

    task automatic do_reset();
        cpu_req = 1'b0; ext_req = 1'b0; cpu_left = 0; ext_left = 0; rnd = 1'b0; ext_lock = 1'b0;
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
    endtask

    bit raised, got;
    int ed_at;

    initial begin
        do_reset();
        chk("rst_cpu_done", cpu_done, 1'b0);
        chk("rst_ext_done", ext_done, 1'b0);
        chk("rst_mem_we2", mem_we2, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);

        // CPU read with fixed latency
        preload(32'h0000_1000, 32'hDEAD_BEEF);
        mark();
        cpu_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_size = 2'b10; cpu_sign = 1'b0;
        cpu_left = 1; cpu_req = 1'b1;
        #1;
        chk("rd_c0_stall", cpu_stall, 1'b1);
        chk("rd_c0_rden", mem_rden2, 1'b0);
        tick();
        chk("rd_c1_rden", mem_rden2, 1'b1);
        chk("rd_c1_addr", mem_addr2, 32'h0000_1000);
        tick();
        chk("rd_c2_rden", mem_rden2, 1'b0);
        chk("rd_c2_stall", cpu_stall, 1'b1);
        tick();
        chk("rd_c3_done", cpu_done, 1'b1);
        chk("rd_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("rd_c3_stall", cpu_stall, 1'b0);
        tick(); tick();

        // CPU byte write
        mark();
        cpu_we = 1'b1; cpu_addr = 32'h0000_2003; cpu_wdata = 32'h0000_00A5; cpu_size = 2'b00;
        cpu_left = 1; cpu_req = 1'b1;
        repeat (6) tick();
        chk("bw_one_write_cycle", wcnt, 1);
        chk("bw_done_cycle", first_cd, 3);

        // Simultaneous requests after reset: CPU first, then alternate
        do_reset();
        mark();
        cpu_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_size = 2'b10; cpu_left = 2; cpu_req = 1'b1;
        ext_we = 1'b1; ext_addr = 32'h0000_3000; ext_wdata = 32'h1234_5678; ext_lock = 1'b0;
        ext_left = 2; ext_req = 1'b1;
        repeat (20) tick();
        chk("sim_cpu_done_cycle", first_cd, 3);
        chk("sim_ext_done_cycle", first_ed, 7);
        chk("sim_count", nseq, 4);
        chk("sim_order", seq[3:0], 4'b0101);

        // Locked EXT burst limited to MAX_BURST while CPU waits
        do_reset();
        mark();
        ext_we = 1'b1; ext_addr = 32'h0000_4000; ext_wdata = 32'hAABB_0000; ext_lock = 1'b1;
        ext_left = 6; ext_req = 1'b1;
        raised = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!raised && n_grant[1] >= 2) begin
                raised = 1'b1;
                cpu_we = 1'b0; cpu_addr = 32'h0000_4000; cpu_size = 2'b10; cpu_left = 1; cpu_req = 1'b1;
            end
        end
        chk("lock_count", nseq, 7);
        chk("lock_order", seq[6:0], 7'b1111011);

        // Protocol violation: EXT drops req during WAIT
        do_reset();
        mark();
        ext_we = 1'b0; ext_addr = 32'h0000_1000; ext_lock = 1'b0; ext_left = 1; ext_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (ext_req && mk == 2) begin ext_req = 1'b0; ext_left = 0; end
        end
        chk("viol_ext_done_once", ed_cnt, 1);
        mark();
        cpu_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_size = 2'b10; cpu_left = 1; cpu_req = 1'b1;
        repeat (6) tick();
        chk("viol_next_cpu_cycle", first_cd, 3);
        chk("viol_next_cpu_once", cd_cnt, 1);

        // Reset in the middle of a CPU write ACCESS
        mark();
        cpu_we = 1'b1; cpu_addr = 32'h0000_5000; cpu_wdata = 32'h0000_0077; cpu_size = 2'b10;
        cpu_left = 1; cpu_req = 1'b1;
        tick();
        chk("racc_we_before", mem_we2, 1'b1);
        RST = 1'b1;
        #1;
        chk("racc_we_dropped", mem_we2, 1'b0);
        chk("racc_addr", mem_addr2, 32'd0);
        chk("racc_cpu_done", cpu_done, 1'b0);
        chk("racc_ext_done", ext_done, 1'b0);
        chk("racc_cpu_rdata", cpu_rdata, 32'd0);
        chk("racc_ext_rdata", ext_rdata, 32'd0);
        chk("racc_stall_follows_req", cpu_stall, 1'b1);
        cpu_req = 1'b0; cpu_left = 0;
        tick(); tick();
        RST = 1'b0;
        chk("racc_no_commit", 32'(dev_mem.exists(32'h0000_5000)), 32'd0);
        cpu_we = 1'b0; cpu_left = 1; cpu_req = 1'b1;
        repeat (6) tick();

        // Burst counter saturation: 258 locked EXT grants, then the CPU must win
        do_reset();
        mark();
        ext_we = 1'b1; ext_addr = 32'h0000_6000; ext_wdata = 32'h0000_0006; ext_lock = 1'b1;
        ext_left = 300; ext_req = 1'b1;
        raised = 1'b0; got = 1'b0; ed_at = -1;
        for (int i = 0; i < 1300 && !got; i++) begin
            tick();
            if (!raised && n_grant[1] >= 258) begin
                raised = 1'b1;
                cpu_we = 1'b0; cpu_addr = 32'h0000_6000; cpu_size = 2'b10; cpu_left = 1; cpu_req = 1'b1;
            end
            if (raised && cd_cnt > 0) begin got = 1'b1; ed_at = ed_cnt; end
        end
        chk("sat_cpu_served", got, 1'b1);
        chk("sat_ext_grants_before_cpu", ed_at, 258);
        ext_left = 0; ext_req = 1'b0;
        repeat (8) tick();

        // Randomized traffic from both requesters
        do_reset();
        rnd = 1'b1; cpu_left = 60; ext_left = 60;
        got = 1'b0;
        for (int i = 0; i < 4000 && !got; i++) begin
            tick();
            if (cpu_left == 0 && ext_left == 0 && mk == 0) got = 1'b1;
        end
        chk("rand_drained", got, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
